// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU issue controller: load-use scoreboard, RUN/STALL/FLUSH
// handshake FSM and a one-cycle registered issue stage.
module alu_issue_ctrl #(
  parameter int LOAD_LAT = 2,
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instValid,
  output logic       instReady,
  input  logic       useImmA,
  input  logic       useImmB,
  input  logic [4:0] rsA,
  input  logic [4:0] rsB,
  input  logic [4:0] rd,
  input  logic       writesRd,
  input  logic       isLoad,
  input  logic       flush,
  output logic       issueValid,
  output logic [1:0] sourceSelect,
  output logic [4:0] issueRd,
  output logic       issueIsLoad,
  output logic [7:0] stallCount
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_e;

  state_e     state_q, state_d;
  logic [1:0] pend_q [NUM_REGS];
  logic [1:0] pend_d [NUM_REGS];
  logic [1:0] pend_a, pend_b;
  logic       hazard, accept, load_wr;

  logic       issue_valid_q, issue_valid_d;
  logic [1:0] src_sel_q, src_sel_d;
  logic [4:0] issue_rd_q, issue_rd_d;
  logic       issue_ld_q, issue_ld_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // Scoreboard lookup; indices beyond NUM_REGS read as never pending.
  always_comb begin
    pend_a = 2'd0;
    pend_b = 2'd0;
    if (int'(rsA) < NUM_REGS) pend_a = pend_q[rsA];
    if (int'(rsB) < NUM_REGS) pend_b = pend_q[rsB];
    hazard = (!useImmA && pend_a != 2'd0) || (!useImmB && pend_b != 2'd0);
  end

  // FSM output: flush and reset both override acceptance combinationally.
  always_comb begin
    instReady = 1'b0;
    if (!reset && !flush) begin
      unique case (state_q)
        ST_RUN, ST_STALL: instReady = !hazard;
        default:          instReady = 1'b0;
      endcase
    end
  end

  assign accept  = instValid && instReady;
  assign load_wr = accept && isLoad && writesRd && (rd != 5'd0);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves a latch.
    state_d = state_q;
    unique case (state_q)
      ST_RUN, ST_STALL: begin
        if (flush)                    state_d = ST_FLUSH;
        else if (instValid && hazard) state_d = ST_STALL;
        else                          state_d = ST_RUN;
      end
      ST_FLUSH: state_d = flush ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // A fresh load beats the countdown of the same register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_d[i] = pend_q[i];
      if (i == 0)                           pend_d[i] = 2'd0;
      else if (load_wr && int'(rd) == i)    pend_d[i] = 2'(LOAD_LAT);
      else if (pend_q[i] != 2'd0)           pend_d[i] = pend_q[i] - 2'd1;
    end
  end

  always_comb begin
    issue_valid_d = accept;
    src_sel_d     = src_sel_q;
    issue_rd_d    = 5'd0;
    issue_ld_d    = 1'b0;
    if (accept) begin
      src_sel_d  = {!useImmA, !useImmB};
      issue_rd_d = writesRd ? rd : 5'd0;
      issue_ld_d = isLoad;
    end
    stall_cnt_d = stall_cnt_q;
    if (instValid && hazard && !flush && stall_cnt_q != 8'hFF)
      stall_cnt_d = stall_cnt_q + 8'd1;
  end

  // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      issue_valid_q <= 1'b0;
      src_sel_q     <= 2'b11;
      issue_rd_q    <= 5'd0;
      issue_ld_q    <= 1'b0;
      stall_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      src_sel_q     <= src_sel_d;
      issue_rd_q    <= issue_rd_d;
      issue_ld_q    <= issue_ld_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // NOTE: the scoreboard array is reset because a stale count would stall a clean pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
    end
  end

  assign issueValid   = issue_valid_q;
  assign sourceSelect = src_sel_q;
  assign issueRd      = issue_rd_q;
  assign issueIsLoad  = issue_ld_q;
  assign stallCount   = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: timestamp scoreboard model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_alu_issue_ctrl;

  localparam int LOAD_LAT = 2;
  localparam int NUM_REGS = 32;

  logic       clk = 1'b0;
  logic       reset, instValid, instReady, useImmA, useImmB;
  logic [4:0] rsA, rsB, rd;
  logic       writesRd, isLoad, flush;
  logic       issueValid, issueIsLoad;
  logic [1:0] sourceSelect;
  logic [4:0] issueRd;
  logic [7:0] stallCount;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.LOAD_LAT(LOAD_LAT), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset),
    .instValid(instValid), .instReady(instReady),
    .useImmA(useImmA), .useImmB(useImmB),
    .rsA(rsA), .rsB(rsB), .rd(rd),
    .writesRd(writesRd), .isLoad(isLoad), .flush(flush),
    .issueValid(issueValid), .sourceSelect(sourceSelect),
    .issueRd(issueRd), .issueIsLoad(issueIsLoad), .stallCount(stallCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a load accepted on edge t makes rd usable from edge t+LOAD_LAT+1 on.
  // FLUSH occupies exactly the cycles following an edge that sampled flush=1.
  int         edge_n;
  int         avail [NUM_REGS];
  bit         prev_flush;
  bit         exp_iv, exp_ld, model_live = 1'b0;
  logic [1:0] exp_ss;
  logic [4:0] exp_rd;
  int         exp_sc;

  function automatic bit busy(input logic [4:0] r);
    return (r != 5'd0) && (edge_n + 1 < avail[r]);
  endfunction

  function automatic bit m_hazard();
    return (!useImmA && busy(rsA)) || (!useImmB && busy(rsB));
  endfunction

  function automatic bit m_ready();
    return !reset && !flush && !prev_flush && !m_hazard();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_n     <= 0;
      for (int i = 0; i < NUM_REGS; i++) avail[i] <= 0;
      prev_flush <= 1'b0;
      exp_iv     <= 1'b0;
      exp_ss     <= 2'b11;
      exp_rd     <= 5'd0;
      exp_ld     <= 1'b0;
      exp_sc     <= 0;
      model_live <= 1'b1;
    end else begin
      edge_n     <= edge_n + 1;
      prev_flush <= flush;
      if (instValid && m_hazard() && !flush && exp_sc < 255) exp_sc <= exp_sc + 1;
      if (instValid && m_ready()) begin
        exp_iv <= 1'b1;
        exp_ss <= {!useImmA, !useImmB};
        exp_rd <= writesRd ? rd : 5'd0;
        exp_ld <= isLoad;
        if (isLoad && writesRd && rd != 5'd0) avail[rd] <= edge_n + 1 + LOAD_LAT + 1;
      end else begin
        exp_iv <= 1'b0;
        exp_rd <= 5'd0;
        exp_ld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("cyc_instReady",    instReady,    m_ready());
      check("cyc_issueValid",   issueValid,   exp_iv);
      check("cyc_sourceSelect", sourceSelect, exp_ss);
      check("cyc_issueRd",      issueRd,      exp_rd);
      check("cyc_issueIsLoad",  issueIsLoad,  exp_ld);
      check("cyc_stallCount",   stallCount,   exp_sc);
    end
  end

  // Presents one instruction and holds it until accepted; returns stall cycles.
  task automatic issue(input bit ld, input bit wr, input bit ia, input bit ib,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       output int waits);
    isLoad = ld; writesRd = wr; useImmA = ia; useImmB = ib;
    rsA = a; rsB = b; rd = d; instValid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (instReady) break;
      waits++;
      if (waits > 20) begin
        tests_run++;
        tests_failed++;
        $display("FAIL issue_timeout: got no acceptance in %0d cycles, expected acceptance", waits);
        break;
      end
    end
    @(posedge clk); #1;
    instValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected completion before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset = 1'b1; instValid = 1'b0; flush = 1'b0; isLoad = 1'b0; writesRd = 1'b0;
    useImmA = 1'b1; useImmB = 1'b1; rsA = '0; rsB = '0; rd = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_instReady",    instReady,    0);
    check("rst_issueValid",   issueValid,   0);
    check("rst_sourceSelect", sourceSelect, 2'b11);
    check("rst_stallCount",   stallCount,   0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Load r5 then dependent add with immediate B.
    issue(1, 1, 0, 1, 5'd0, 5'd0, 5'd5, w);
    check("lu_load_issueRd", issueRd, 5);
    check("lu_load_isLoad",  issueIsLoad, 1);
    issue(0, 1, 0, 1, 5'd5, 5'd0, 5'd6, w);
    check("lu_stall_cycles", w, LOAD_LAT);
    check("lu_sourceSelect", sourceSelect, 2'b10);
    check("lu_stallCount",   stallCount, 2);

    // Immediates bypass the pending r7.
    issue(1, 1, 1, 1, 5'd0, 5'd0, 5'd7, w);
    issue(0, 1, 1, 1, 5'd7, 5'd7, 5'd8, w);
    check("imm_stall_cycles", w, 0);
    check("imm_sourceSelect", sourceSelect, 2'b00);

    // Register 0 is never pending.
    issue(1, 1, 1, 1, 5'd0, 5'd0, 5'd0, w);
    check("r0_load_issueRd", issueRd, 0);
    issue(0, 1, 0, 0, 5'd0, 5'd0, 5'd1, w);
    check("r0_stall_cycles", w, 0);
    check("r0_sourceSelect", sourceSelect, 2'b11);

    // Flush while stalled on r3.
    issue(1, 1, 1, 1, 5'd0, 5'd0, 5'd3, w);
    isLoad = 0; writesRd = 1; useImmA = 0; useImmB = 1; rsA = 5'd3; rsB = 0; rd = 5'd10;
    instValid = 1'b1;
    @(negedge clk);
    check("fl_stalled_ready", instReady, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_flush_ready", instReady, 0);
    @(posedge clk); #1;
    flush = 1'b0; instValid = 1'b0;
    check("fl_issueValid_a", issueValid, 0);
    @(negedge clk);
    check("fl_state_ready", instReady, 0);
    @(posedge clk); #1;
    check("fl_issueValid_b", issueValid, 0);
    issue(0, 1, 0, 1, 5'd3, 5'd0, 5'd10, w);
    check("fl_after_stall_cycles", w, 0);
    check("fl_stallCount", stallCount, 3);

    // Keep r9 pending by reloading it, saturating the stall counter.
    issue(1, 1, 1, 1, 5'd0, 5'd0, 5'd9, w);
    for (int k = 0; k < 300; k++) begin
      isLoad = 0; writesRd = 1; useImmA = 0; useImmB = 1; rsA = 5'd9; rsB = 0; rd = 5'd11;
      instValid = 1'b1;
      @(posedge clk); #1;
      issue(1, 1, 1, 1, 5'd0, 5'd0, 5'd9, w);
      check("sat_reload_accept", w, 0);
    end
    check("sat_stallCount", stallCount, 255);
    issue(0, 1, 0, 1, 5'd9, 5'd0, 5'd11, w);
    check("sat_reload_restores", w, LOAD_LAT);

    // Reset while the consumer of r4 is stalling and pend[4] is full.
    issue(1, 1, 0, 1, 5'd0, 5'd0, 5'd4, w);
    isLoad = 0; writesRd = 1; useImmA = 0; useImmB = 1; rsA = 5'd4; rsB = 0; rd = 5'd12;
    instValid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mrst_instReady",    instReady,    0);
    check("mrst_issueValid",   issueValid,   0);
    check("mrst_sourceSelect", sourceSelect, 2'b11);
    check("mrst_issueRd",      issueRd,      0);
    check("mrst_issueIsLoad",  issueIsLoad,  0);
    check("mrst_stallCount",   stallCount,   0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("mrst_release_ready", instReady, 1);
    @(posedge clk); #1;
    instValid = 1'b0;
    check("mrst_first_issue",  issueValid,   1);
    check("mrst_first_ss",     sourceSelect, 2'b10);
    check("mrst_first_rd",     issueRd,      12);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
